// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the MEM stage and a 32-bit data memory.
// Stores retire in one cycle and drain to memory when no load owns the port.
// Loads are checked against pending entries: an exact match forwards the youngest
// data, and any partial byte overlap stalls the load while the buffer drains.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       fwd_hit,
    output logic [DW-1:0]              fwd_data,
    output logic                       ld_stall,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    output logic                       mem_we,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];

    logic          w_full;
    logic          w_push;
    logic          w_drain;
    logic          w_any_ovl;
    logic          w_any_exact;
    logic [DW-1:0] w_fwd_word;
    logic [PW-1:0] w_idx;
    logic [AW-1:0] w_diff;
    logic [AW-1:0] w_head_addr;
    logic [DW-1:0] w_head_data;

    assign count       = r_wr_ptr - r_rd_ptr;
    assign empty       = (count == '0);
    assign w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                         (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_head_addr = r_addr[r_rd_ptr[PW-1:0]];
    assign w_head_data = r_data[r_rd_ptr[PW-1:0]];

    // Scan occupied entries oldest to youngest; a later exact match overrides an
    // earlier one, so the surviving word is the youngest. The difference is
    // checked in both directions to catch overlaps below and above ld_addr.
    always_comb begin
        w_any_ovl   = 1'b0;
        w_any_exact = 1'b0;
        w_fwd_word  = '0;
        w_idx       = '0;
        w_diff      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx  = r_rd_ptr[PW-1:0] + PW'(k);
            w_diff = r_addr[w_idx] - ld_addr;
            if (CW'(k) < count) begin
                if (w_diff == '0) begin
                    w_any_exact = 1'b1;
                    w_fwd_word  = r_data[w_idx];
                end else if ((w_diff < AW'(4)) || ((AW'(0) - w_diff) < AW'(4))) begin
                    w_any_ovl = 1'b1;
                end
            end
        end
    end

    assign ld_stall = ld_valid && w_any_ovl;
    assign fwd_hit  = ld_valid && !w_any_ovl && w_any_exact;
    assign fwd_data = fwd_hit ? w_fwd_word : '0;

    // A stalled load yields the port to the drain, otherwise it could never clear.
    assign w_drain  = !empty && (!ld_valid || ld_stall);
    assign st_ready = !w_full && !ld_valid;
    assign w_push   = st_valid && st_ready;

    // Memory port mux: unstalled load, else drain head, else idle zeros.
    always_comb begin
        mem_we    = w_drain;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_valid && !ld_stall) begin
            mem_addr = ld_addr;
        end else if (w_drain) begin
            mem_addr  = w_head_addr;
            mem_wdata = w_head_data;
        end
    end

    // Pointer update; reset discards every pending entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)  r_wr_ptr <= r_wr_ptr + CW'(1);
            if (w_drain) r_rd_ptr <= r_rd_ptr + CW'(1);
        end
    end

    // Entry storage; validity comes from the pointers, so data needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr[PW-1:0]] <= st_addr;
            r_data[r_wr_ptr[PW-1:0]] <= st_data;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed stimulus with a queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        ld_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [2:0]  count;
    logic        empty;

    store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_stall(ld_stall),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];      // model: pending stores, oldest first
    ent_t wlog[$];   // writes the DUT actually issued
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluated at every negedge while inputs are stable.
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit          ovl, ex, e_stall, e_hit, e_drain, e_ready;
                logic [31:0] fd, e_addr, e_wdata;
                longint      diff;
                int          n;
                if (!rst_n) q.delete();
                n = q.size();
                ovl = 0; ex = 0; fd = '0;
                foreach (q[i]) begin
                    diff = longint'(q[i].a) - longint'(ld_addr);
                    if (diff == 0) begin ex = 1; fd = q[i].d; end
                    else if (diff > -4 && diff < 4) ovl = 1;
                end
                e_stall = ld_valid && ovl;
                e_hit   = ld_valid && !ovl && ex;
                e_drain = (n > 0) && (!ld_valid || e_stall);
                e_ready = (n < DEPTH) && !ld_valid;
                e_addr  = '0; e_wdata = '0;
                if (ld_valid && !e_stall) e_addr = ld_addr;
                else if (e_drain) begin e_addr = q[0].a; e_wdata = q[0].d; end
                chk("st_ready", st_ready, e_ready);
                chk("fwd_hit", fwd_hit, e_hit);
                chk("fwd_data", fwd_data, e_hit ? fd : 32'h0);
                chk("ld_stall", ld_stall, e_stall);
                chk("mem_we", mem_we, e_drain);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wdata", mem_wdata, e_wdata);
                chk("count", count, n);
                chk("empty", empty, n == 0);
                if (mem_we) wlog.push_back('{a: mem_addr, d: mem_wdata});
                if (rst_n) begin
                    if (e_drain) void'(q.pop_front());
                    if (st_valid && e_ready) q.push_back('{a: st_addr, d: st_data});
                end
            end
        end
    end

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic cyc(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
        @(posedge clk);
        #1;
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1'b1);
        chk("rst_ready", st_ready, 1'b1);
        chk("rst_we", mem_we, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Reset mid-traffic: one entry held by a blocking load, then async reset.
        cyc(1'b1, 32'h0000_0200, 32'h5555_5555, 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, 32'h0000_0080);
        #1;
        chk("pre_rst_count", count, 3'd1);
        rst_n = 1'b0;
        #1;
        chk("async_count", count, 3'd0);
        chk("async_empty", empty, 1'b1);
        chk("async_we", mem_we, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        wlog.delete();
        idle(3);
        @(posedge clk);
        chk("no_write_after_rst", wlog.size(), 0);

        // Fill/drain: four stores in a row drain in order.
        wlog.delete();
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, '0);
            #2;
            chk("fill_ready", st_ready, 1'b1);
        end
        idle(2);
        @(posedge clk);
        chk("fill_nwr", wlog.size(), 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("fill_addr", wlog[i].a, 32'h10 + 32'(4 * i));
            chk("fill_data", wlog[i].d, 32'hA0 + 32'(i));
        end
        chk("fill_empty", empty, 1'b1);

        // Load held: stores are refused while the load owns the port.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 32'h300 + 32'(4 * i), 32'(i), 1'b1, 32'h80);
            #2;
            chk("ld_block_ready", st_ready, 1'b0);
            chk("ld_block_addr", mem_addr, 32'h80);
        end
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h300 + 32'(4 * i), 32'(i), 1'b0, '0);
        #2;
        chk("push_count", count, 3'd1);
        idle(2);

        // Forward youngest matching store.
        cyc(1'b1, 32'h20, 32'h11, 1'b0, '0);
        cyc(1'b1, 32'h20, 32'h22, 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, 32'h20);
        #2;
        chk("fwd_hit", fwd_hit, 1'b1);
        chk("fwd_data", fwd_data, 32'h22);
        chk("fwd_we", mem_we, 1'b0);
        idle(2);

        // Partial overlap above the entry: stall, port goes to the drain.
        cyc(1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, 32'h42);
        #2;
        chk("ovl_stall", ld_stall, 1'b1);
        chk("ovl_we", mem_we, 1'b1);
        chk("ovl_addr", mem_addr, 32'h40);
        chk("ovl_wdata", mem_wdata, 32'hDEAD_BEEF);
        cyc(1'b0, '0, '0, 1'b1, 32'h42);
        #2;
        chk("ovl_clear", ld_stall, 1'b0);
        chk("ovl_nohit", fwd_hit, 1'b0);
        chk("ovl_ldaddr", mem_addr, 32'h42);
        idle(1);

        // Partial overlap below the entry.
        cyc(1'b1, 32'h60, 32'h1234_5678, 1'b0, '0);
        cyc(1'b0, '0, '0, 1'b1, 32'h5E);
        #2;
        chk("ovl_lo_stall", ld_stall, 1'b1);
        chk("ovl_lo_addr", mem_addr, 32'h60);
        idle(2);

        // Wrap: ten back-to-back pushes, each overlapping a drain.
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 32'h100 + 32'(4 * i), 32'h1111 * 32'(i + 1), 1'b0, '0);
            #2;
            chk("wrap_count", count, (i == 0) ? 3'd0 : 3'd1);
        end
        idle(2);
        @(posedge clk);
        chk("wrap_nwr", wlog.size(), 10);
        for (int i = 0; i < 10 && i < wlog.size(); i++) begin
            chk("wrap_addr", wlog[i].a, 32'h100 + 32'(4 * i));
            chk("wrap_data", wlog[i].d, 32'h1111 * 32'(i + 1));
        end

        idle(2);
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
